counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 90 +++++++++
 tb/tb_counter_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: round-robin granted event counter with optional COUNT-state timeout.
// Define COUNTER_CTRL_TIMEOUT_EN to build the 8-bit TO_CYCLES timer and err pulses.
module counter_ctrl #(
  parameter int TO_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] tgt0,
  input  logic [1:0] tgt1,
  input  logic       c,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic [1:0] count,
  output logic       out
);
  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, FIN} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_gnt, r_tl, r_count, w_inc;
  logic       r_lp, w_g, w_win, w_abort, w_met, w_to, w_fin_err;
  if (TO_CYCLES < 1 || TO_CYCLES > 256) begin : g_bad_to
    $error("TO_CYCLES must fit the 8-bit timer");
  end
  assign w_g     = r_gnt[1];
  assign w_win   = req[~r_lp] ? ~r_lp : r_lp;
  assign w_abort = (r_state == CLEAR || r_state == COUNT) && !(|(req & r_gnt));
  assign w_inc   = (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
  assign w_met   = c && (w_inc == r_tl);
`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic [7:0] r_timer;
  logic       r_to;
  // a target met on the timeout edge still reports done
  assign w_to      = (r_timer == 8'(TO_CYCLES - 1)) && !w_met;
  assign w_fin_err = r_to;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 8'd0;
      r_to    <= 1'b0;
    end else begin
      r_timer <= (r_state == CLEAR) ? 8'd0 : (r_state == COUNT) ? r_timer + 8'd1 : r_timer;
      r_to    <= (r_state == COUNT) && !w_abort && w_to;
    end
  end
`else
  assign w_to      = 1'b0;
  assign w_fin_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |req ? CLEAR : IDLE;
      CLEAR:   w_next = w_abort ? IDLE : (r_tl == 2'd0) ? FIN : COUNT;
      COUNT:   w_next = w_abort ? IDLE : (w_met || w_to) ? FIN : COUNT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    gnt   = r_gnt;
    busy  = r_state != IDLE;
    done  = (r_state == FIN && !w_fin_err) ? r_gnt : 2'b00;
    err   = (r_state == FIN && w_fin_err) ? r_gnt : 2'b00;
    count = r_count;
    out   = r_count == 2'd3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt   <= 2'b00;
      r_tl    <= 2'd0;
      r_count <= 2'd0;
      r_lp    <= 1'b1;
    end else begin
      if (r_state == IDLE && |req) begin
        r_gnt <= w_win ? 2'b10 : 2'b01;
        r_tl  <= w_win ? tgt1 : tgt0;
      end
      if (r_state != IDLE && w_next == IDLE) begin
        r_gnt <= 2'b00;
        r_lp  <= w_g;
      end
      if (r_state == CLEAR) r_count <= 2'd0;
      else if (r_state == COUNT && c) r_count <= w_inc;
    end
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_counter_ctrl;
  localparam int TO = 8;
  logic clk = 0, rst = 1, c = 0;
  logic [1:0] req = 0, tgt0 = 0, tgt1 = 0;
  logic [1:0] gnt, done, err, count;
  logic busy, out;
  int checks = 0, failures = 0;
  int m_st, m_own, m_lp, m_cnt, m_tl, m_tmr, m_to;
  counter_ctrl #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .tgt0(tgt0), .tgt1(tgt1), .c(c),
    .gnt(gnt), .busy(busy), .done(done), .err(err), .count(count), .out(out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  // stage: 0 idle, 1 clear, 2 counting, 3 finishing
  task automatic model_step();
    int prev, nc;
    bit met, drop;
    if (rst) begin
      m_st = 0; m_own = 0; m_cnt = 0; m_tl = 0; m_lp = 1; m_tmr = 0; m_to = 0;
      return;
    end
    prev = m_st;
    drop = (m_st == 1 || m_st == 2) && !req[m_own];
    case (m_st)
      0: if (req != 0) begin
        m_own = req[1 - m_lp] ? 1 - m_lp : m_lp;
        m_tl  = m_own ? int'(tgt1) : int'(tgt0);
        m_st  = 1;
      end
      1: begin
        m_cnt = 0; m_tmr = 0; m_to = 0;
        m_st = drop ? 0 : (m_tl == 0 ? 3 : 2);
      end
      2: begin
        nc = c ? (m_cnt < 3 ? m_cnt + 1 : 3) : m_cnt;
        met = c && nc == m_tl;
        m_cnt = nc;
        if (drop) m_st = 0;
        else if (met) begin m_st = 3; m_to = 0; end
`ifdef COUNTER_CTRL_TIMEOUT_EN
        else if (m_tmr == TO - 1) begin m_st = 3; m_to = 1; end
`endif
        m_tmr++;
      end
      default: m_st = 0;
    endcase
    if (prev != 0 && m_st == 0) m_lp = m_own;
  endtask
  task automatic cyc();
    logic [7:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_st != 0) ? (8'd1 << m_own) : 8'd0;
    check("gnt", 8'(gnt), eg);
    check("busy", 8'(busy), 8'(m_st != 0));
    check("done", 8'(done), (m_st == 3 && m_to == 0) ? eg : 8'd0);
    check("err", 8'(err), (m_st == 3 && m_to == 1) ? eg : 8'd0);
    check("count", 8'(count), 8'(m_cnt));
    check("out", 8'(out), 8'(m_cnt == 3));
  endtask
  initial begin
    int nd;
    logic [1:0] seq [$];
    logic [1:0] pg;
    rst = 1; cyc(); cyc();
    rst = 0; req = 2'b01; tgt0 = 3; c = 1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) check("r31_gnt", 8'(gnt), 8'd1);
      if (done == 2'b01) begin nd++; check("r31_out", 8'(out), 8'd1); end
    end
    check("r31_done_cnt", 8'(nd), 8'd1);
    req = 0; c = 0; cyc(); cyc(); cyc(); cyc(); cyc();
    rst = 1; cyc();
    rst = 0; req = 2'b11; tgt0 = 0; tgt1 = 0; pg = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (gnt != 0 && pg == 0) seq.push_back(gnt);
      pg = gnt;
    end
    check("r32_n", 8'(seq.size() >= 3), 8'd1);
    if (seq.size() >= 3) begin
      check("r32_g1", 8'(seq[0]), 8'd1);
      check("r32_g2", 8'(seq[1]), 8'd2);
      check("r32_g3", 8'(seq[2]), 8'd1);
    end
    req = 0; cyc(); cyc(); cyc(); cyc();
    req = 2'b10; tgt1 = 0; cyc(); cyc();
    check("r33_done", 8'(done), 8'd2);
    req = 0; cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    req = 2'b01; tgt0 = 2; c = 0; cyc(); cyc();
    c = 1; cyc();
    c = 0; req = 0; cyc();
    check("r34_idle", 8'(busy), 8'd0);
    check("r34_count", 8'(count), 8'd1);
    req = 2'b11; tgt1 = 0; cyc();
    check("r34_tie", 8'(gnt), 8'd2);
    req = 0; cyc(); cyc(); cyc();
    req = 2'b01; tgt0 = 3; c = 1; cyc(); cyc(); cyc(); cyc();
    check("r35_pre", 8'(count), 8'd2);
    rst = 1; cyc();
    check("r35_count", 8'(count), 8'd0);
    rst = 0; req = 0; c = 0; cyc();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      for (int b = 0; b < 2; b++)
        req[b] = req[b] ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
      c = ($urandom_range(2) != 0) && (i % 400 < 300);
      tgt0 = 2'($urandom);
      tgt1 = 2'($urandom);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
